moody_source: RTL
=================

# moody_source

Packet traffic generator at the injection side of the NoC: the producer end of the same req/busy parallel handshake that a moody_sink consumes. It decides pseudo-randomly, once per idle cycle, whether to inject, with a tunable eagerness. When it injects, it builds a {header, payload, address} word and holds it on the handshake until the downstream side accepts it. Its parallel output drives the serializer (tx) or a router input port directly. It is used with moody_sink to stress flow control from both ends.

## Interface
- id, -1, source identifier; when not -1, each accepted packet is logged.
- eagerness, 0, injection willingness 0..255; 0 never injects, 255 injects every idle cycle.
- dest, -1, fixed destination address; -1 selects a random destination.
- num_dests, 16, destination range used when dest = -1; valid range 1..2^`ADDR_SZ.
- max_packets, 0, packet budget; 0 means unlimited.
- seed, 16'hACE1, LFSR reset value; 0 is replaced by 16'hACE1.

- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- busy  input  1  downstream not ready; a transfer occurs on a posedge where req & !busy.
- req  output  1  packet offered.
- data  output  `HDR_SZ+`PL_SZ+`ADDR_SZ  packet {hdr, payload, addr}; hdr is the MSBs, addr the LSBs.
- done  output  1  packet budget exhausted.
- sent_count  output  16  accepted packets, wraps at 65535→0.

## Operation
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It loads seed on reset and advances on every clock out of reset, in every state.
- rand8 = lfsr[7:0]. The inject condition is:
  - eagerness == 255, or
  - eagerness != 0 and rand8 < eagerness.
- Packet fields at build time:
  - hdr = seq[`HDR_SZ-1:0]; seq is a 16-bit counter reset to 0.
  - payload = lfsr[`PL_SZ-1:0], zero-extended if `PL_SZ > 16.
  - addr = dest[`ADDR_SZ-1:0] when dest != -1, else lfsr[15:8] % num_dests.
- FSM has two states, IDLE and OFFER.
  - IDLE: when !done and the inject condition holds, register data, set req=1, go to OFFER. Otherwise stay in IDLE with req=0.
  - OFFER: req=1, and data is held bit-stable. On a posedge with busy=0:
    - transfer occurs;
    - req←0;
    - seq and sent_count each increment by 1;
    - return to IDLE.
  - OFFER with busy=1: hold everything.
- Budget: done←1 on the transfer that makes the accepted count equal max_packets. done is sticky until reset. While done, the block stays in IDLE and never raises req. With max_packets=0, done stays 0.
- Logging: on each transfer, when id != -1, print $display("##,tx,%d,%d", id, hdr). This line is simulation-only.
- data keeps its last value after a transfer; only req qualifies it.

## Timing
- Reset values:
  - req=0, data=0, done=0, sent_count=0;
  - seq=0, state=IDLE, lfsr=seed.
- A reset asserted in OFFER drops req immediately (asynchronous). The pending packet is discarded and not counted.
- Inject latency: the inject decision is made on posedge N; req and data are valid after posedge N.
- The earliest acceptance is posedge N+1 when busy=0 there. req then falls after posedge N+1.
- Minimum spacing is 2 cycles per packet, because of the mandatory IDLE cycle. Maximum throughput is 1 packet per 2 clocks.
- busy is sampled only at posedges. Changes to busy between edges are ignored. req never depends combinationally on busy.
- Simultaneous events:
  - A transfer on the budget-final packet sets done on the same edge that req falls.
  - sent_count wrap from 65535 to 0 has no side effects.

## Test plan
- Reset check: assert reset mid-cycle → req=0, data=0, done=0, sent_count=0 immediately, with no clock edge required.
- Full rate: eagerness=255, dest=5, busy=0, 10 cycles → req high on alternate cycles, 5 transfers, hdr=0,1,2,3,4, addr=5 on every transfer, sent_count=5.
- Backpressure: eagerness=255, busy=1 for 20 cycles after req rises → req stays 1 and data is unchanged every cycle. Release busy → exactly one transfer, sent_count=1, hdr=0.
- Budget: max_packets=3, eagerness=255, busy=0 → done rises on the 3rd transfer edge. req stays 0 for the following 100 cycles and sent_count stays at 3.
- Silence and randomness: eagerness=0 for 1000 cycles → req never 1. Then eagerness=128, dest=-1, num_dests=4, 2000 cycles, busy=0 → transfer count is between 300 and 700, and every addr is < 4.
- Reset mid-offer: busy=1, req=1, hdr=0, pulse reset → req=0 at once. After release and busy=0, the first accepted hdr=0 and sent_count=1.

Source files
------------

// File: rtl/moody_source.sv
// Pseudo-random packet injector for the NoC. It drives the producer side of the
// req/busy handshake and offers {hdr, payload, addr} words with tunable eagerness.
`ifndef HDR_SZ
`define HDR_SZ 8
`endif
`ifndef PL_SZ
`define PL_SZ 16
`endif
`ifndef ADDR_SZ
`define ADDR_SZ 4
`endif

module moody_source #(
    parameter int          id          = -1,
    parameter int          eagerness   = 0,
    parameter int          dest        = -1,
    parameter int          num_dests   = 16,
    parameter int          max_packets = 0,
    parameter logic [15:0] seed        = 16'hACE1
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               busy,
    output logic                               req,
    output logic [`HDR_SZ+`PL_SZ+`ADDR_SZ-1:0] data,
    output logic                               done,
    output logic [15:0]                        sent_count
);
    localparam int          HDR       = `HDR_SZ;
    localparam int          PL        = `PL_SZ;
    localparam int          ADDR      = `ADDR_SZ;
    localparam int          DW        = HDR + PL + ADDR;
    localparam logic [15:0] LFSR_INIT = (seed == 16'h0000) ? 16'hACE1 : seed;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;  // x^16+x^14+x^13+x^11+1, right-shifting
    localparam int          ND        = (num_dests < 1) ? 1 : num_dests;
    localparam logic [15:0] BUDGET    = 16'(max_packets);

    typedef enum logic {IDLE, OFFER} state_e;

    state_e          state_q, state_d;
    logic [15:0]     lfsr_q, lfsr_d;
    logic [15:0]     cnt_q, cnt_d;
    logic [DW-1:0]   data_q, data_d;
    logic            done_q, done_d;
    logic            inject;
    logic            xfer;
    logic [ADDR-1:0] addr;

    assign inject = (eagerness >= 255) ||
                    ((eagerness > 0) && (int'(lfsr_q[7:0]) < eagerness));

    always_comb begin
        if (dest != -1) addr = ADDR'(dest);
        else            addr = ADDR'(int'(lfsr_q[15:8]) % ND);
    end

    // The sequence number and the accepted count advance together, so one counter serves both.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_d = state_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        xfer    = 1'b0;
        lfsr_d  = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
        case (state_q)
            IDLE: begin
                if (!done_q && inject) begin
                    data_d  = {HDR'(cnt_q), PL'(lfsr_q), addr};
                    state_d = OFFER;
                end
            end
            OFFER: begin
                if (!busy) begin
                    xfer    = 1'b1;
                    state_d = IDLE;
                    cnt_d   = cnt_q + 16'd1;
                    if ((max_packets != 0) && (cnt_d == BUDGET)) done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lfsr_q  <= LFSR_INIT;
            cnt_q   <= 16'd0;
            data_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            done_q  <= done_d;
        end
    end

    assign req        = (state_q == OFFER);
    assign data       = data_q;
    assign done       = done_q;
    assign sent_count = cnt_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!reset && xfer && (id != -1))
            $display("##,tx,%d,%d", id, data_q[DW-1 -: HDR]);
    end
`endif

endmodule
